// File: rtl/doorlock_keypad_ctrl.sv
// Keypad sequencer for the door lock decoder: entry timeout, fail counting, timed lockout.
// Optional DOORLOCK_KEY_SYNC_EN: 2-flop synchronisers plus edge detect on the key inputs.
module doorlock_keypad_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CHECK_CYCLES   = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       door_open,
  output logic [1:0] state,
  output logic [3:0] ps_num,
  output logic       lockout,
  output logic [1:0] fail_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCK} fsm_e;

  localparam int CMAX0 = (TIMEOUT_CYCLES > CHECK_CYCLES) ? TIMEOUT_CYCLES : CHECK_CYCLES;
  localparam int CMAX  = (CMAX0 > LOCKOUT_CYCLES) ? CMAX0 : LOCKOUT_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  logic       kv, ke, kc;
  logic [3:0] kcode;

`ifdef DOORLOCK_KEY_SYNC_EN
  // Bit order in the sync vectors: {clear, enter, valid}.
  logic [2:0] s1_q, s2_q, s3_q, ev_q, ev_d;
  logic [3:0] c1_q, c2_q, c3_q;

  always_comb ev_d = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0; s2_q <= '0; s3_q <= '0; ev_q <= '0;
      c1_q <= '0; c2_q <= '0; c3_q <= '0;
    end else begin
      s1_q <= {key_clear, key_enter, key_valid};
      s2_q <= s1_q;
      s3_q <= s2_q;
      ev_q <= ev_d;
      c1_q <= key_code;
      c2_q <= c1_q;
      c3_q <= c2_q;
    end
  end

  assign kv    = ev_q[0];
  assign ke    = ev_q[1];
  assign kc    = ev_q[2];
  assign kcode = c3_q;
`else
  assign kv    = key_valid;
  assign ke    = key_enter;
  assign kc    = key_clear;
  assign kcode = key_code;
`endif

  fsm_e          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ps_num_q, ps_num_d;
  logic [1:0]    fail_cnt_q, fail_cnt_d, fail_next;
  logic [1:0]    state_q, state_d;
  logic          lockout_q, lockout_d;

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    ps_num_d   = ps_num_q;
    fail_cnt_d = fail_cnt_q;
    fail_next  = (fail_cnt_q >= 2'(MAX_FAIL)) ? 2'(MAX_FAIL) : fail_cnt_q + 2'd1;
    case (fsm_q)
      S_IDLE: begin
        if (kv) begin
          fsm_d    = S_ENTRY;
          ps_num_d = kcode;
          cnt_d    = '0;
        end
      end
      S_ENTRY: begin
        // A digit arriving with enter or clear is dropped.
        if (kc) begin
          fsm_d    = S_IDLE;
          ps_num_d = '0;
          cnt_d    = '0;
        end else if (ke) begin
          fsm_d = S_CHECK;
          cnt_d = '0;
        end else if (kv) begin
          ps_num_d = kcode;
          cnt_d    = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          fsm_d    = S_IDLE;
          ps_num_d = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (cnt_q == CW'(CHECK_CYCLES - 1)) begin
          ps_num_d = '0;
          cnt_d    = '0;
          if (door_open) begin
            fail_cnt_d = '0;
            fsm_d      = S_IDLE;
          end else begin
            fail_cnt_d = fail_next;
            fsm_d      = (fail_next == 2'(MAX_FAIL)) ? S_LOCK : S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCK: begin
        if (cnt_q == CW'(LOCKOUT_CYCLES - 1)) begin
          fsm_d      = S_IDLE;
          fail_cnt_d = '0;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        fsm_d = S_IDLE;
        cnt_d = '0;
      end
    endcase
    // Lock-facing outputs are decoded from the next state so they leave a flop directly.
    case (fsm_d)
      S_ENTRY: state_d = 2'b01;
      S_CHECK: state_d = 2'b10;
      default: state_d = 2'b00;
    endcase
    lockout_d = (fsm_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      cnt_q      <= '0;
      ps_num_q   <= '0;
      fail_cnt_q <= '0;
      state_q    <= '0;
      lockout_q  <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      ps_num_q   <= ps_num_d;
      fail_cnt_q <= fail_cnt_d;
      state_q    <= state_d;
      lockout_q  <= lockout_d;
    end
  end

  assign state    = state_q;
  assign ps_num   = ps_num_q;
  assign lockout  = lockout_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_doorlock_keypad_ctrl.sv
// Bench for doorlock_keypad_ctrl: deadline-based reference model feeds a per-cycle
// expected-output queue; a monitor on the falling edge pops and compares.
module tb_doorlock_keypad_ctrl;

  localparam int TIMEOUT  = 8;
  localparam int CHECK    = 2;
  localparam int MAX_FAIL = 3;
  localparam int LOCKOUT  = 16;
  localparam logic [3:0] SECRET = 4'hD;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_CHECK = 2;
  localparam int M_LOCK  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid, key_enter, key_clear;
  logic [3:0] key_code;
  logic       door_open;
  logic [1:0] state;
  logic [3:0] ps_num;
  logic       lockout;
  logic [1:0] fail_cnt;

  doorlock_keypad_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CHECK_CYCLES  (CHECK),
    .MAX_FAIL      (MAX_FAIL),
    .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_enter(key_enter),
    .key_clear(key_clear),
    .door_open(door_open),
    .state    (state),
    .ps_num   (ps_num),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
  );

  // Lock decoder stand-in: opens only for the secret digit while being checked.
  assign door_open = (state == 2'b10) && (ps_num == SECRET);

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the keypad session is doing, with absolute-cycle deadlines.
  int         m_mode;
  logic [3:0] m_digit;
  int         m_fails;
  int         now, deadline, check_end, lock_end;

  function automatic logic [8:0] pack_out(input logic [1:0] s, input logic [3:0] d,
                                          input logic l, input logic [1:0] f);
    return {s, d, l, f};
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_digit = 4'h0;
    m_fails = 0;
    now     = 0;
  endtask

  task automatic check_zero(input string tag);
    logic [8:0] act;
    act = pack_out(state, ps_num, lockout, fail_cnt);
    n_checks++;
    if (act !== 9'h0) begin
      n_fail++;
      $display("FAIL %s: got state=%b ps_num=%h lockout=%b fail_cnt=%0d, expected all zero",
               tag, state, ps_num, lockout, fail_cnt);
    end
  endtask

  // One clock of stimulus; called just after a falling edge.
  task automatic step(input logic v, input logic [3:0] c, input logic e, input logic cl);
    logic       door;
    logic [1:0] st;
    key_valid = v;
    key_code  = c;
    key_enter = e;
    key_clear = cl;
    now++;
    door = (m_mode == M_CHECK) && (m_digit == SECRET);
    case (m_mode)
      M_IDLE: begin
        if (v) begin
          m_mode   = M_ENTRY;
          m_digit  = c;
          deadline = now + TIMEOUT;
        end
      end
      M_ENTRY: begin
        if (cl) begin
          m_mode  = M_IDLE;
          m_digit = 4'h0;
        end else if (e) begin
          m_mode    = M_CHECK;
          check_end = now + CHECK;
        end else if (v) begin
          m_digit  = c;
          deadline = now + TIMEOUT;
        end else if (now == deadline) begin
          m_mode  = M_IDLE;
          m_digit = 4'h0;
        end
      end
      M_CHECK: begin
        if (now == check_end) begin
          m_digit = 4'h0;
          if (door) begin
            m_fails = 0;
            m_mode  = M_IDLE;
          end else begin
            m_fails = (m_fails < MAX_FAIL) ? m_fails + 1 : MAX_FAIL;
            if (m_fails == MAX_FAIL) begin
              m_mode   = M_LOCK;
              lock_end = now + LOCKOUT;
            end else begin
              m_mode = M_IDLE;
            end
          end
        end
      end
      default: begin
        if (now == lock_end) begin
          m_mode  = M_IDLE;
          m_fails = 0;
        end
      end
    endcase
    st = (m_mode == M_ENTRY) ? 2'b01 : (m_mode == M_CHECK) ? 2'b10 : 2'b00;
    exp_q.push_back(pack_out(st, m_digit, m_mode == M_LOCK, 2'(m_fails)));
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    exp_q.delete();
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_code = 4'h0;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic attempt(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    idle(3);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [8:0] exp, act;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = pack_out(state, ps_num, lockout, fail_cnt);
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got state=%b ps_num=%h lockout=%b fail_cnt=%0d, expected state=%b ps_num=%h lockout=%b fail_cnt=%0d",
                 $time, act[8:7], act[6:3], act[2], act[1:0], exp[8:7], exp[6:3], exp[2], exp[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int vp, ep, cp;
    logic [3:0] d;
    rst_n = 1'b0;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; key_code = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset_initial");
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Correct code opens the door.
    attempt(SECRET);
    // Enter/clear in IDLE do nothing.
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    // Three wrong codes lead to lockout; keys during lockout are ignored.
    attempt(4'h3);
    attempt(4'h3);
    attempt(4'h3);
    for (int i = 0; i < 6; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    idle(14);
    // Entry timeout.
    step(1'b1, 4'h5, 1'b0, 1'b0);
    idle(12);
    // Clear beats enter; enter beats a same-cycle digit.
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    idle(2);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b1, 1'b0);
    idle(4);
    // Reset mid-CHECK and mid-LOCKOUT.
    step(1'b1, 4'h4, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    do_reset("reset_mid_check");
    attempt(4'h1);
    attempt(4'h1);
    attempt(4'h1);
    idle(5);
    do_reset("reset_mid_lockout");

    // Randomized traffic with varying key density.
    for (int blk = 0; blk < 30; blk++) begin
      vp = $urandom_range(2, 40);
      ep = $urandom_range(2, 25);
      cp = $urandom_range(0, 8);
      for (int i = 0; i < 100; i++) begin
        d = ($urandom_range(0, 1) == 0) ? SECRET : 4'($urandom_range(0, 15));
        step($urandom_range(0, 99) < vp, d, $urandom_range(0, 99) < ep,
             $urandom_range(0, 99) < cp);
      end
      if ($urandom_range(0, 9) == 0) do_reset("reset_random");
    end
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
